// File: rtl/tape_mem.sv
// rtl/tape_mem.sv - data tape for the threadbrain ALU: cleared register array with forwarding read and debug port
module tape_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ptr_select,
    input  logic [15:0]       ptr_wb,
    input  logic [DATA_W-1:0] wb_val,
    input  logic              wb_en,
    output logic [DATA_W-1:0] val_in,
    output logic              ready,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              oob
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] sel_idx;
    logic [ADDR_W-1:0] wb_idx;
    logic              sel_oob;
    logic              wb_oob;
    logic [DATA_W-1:0] mem [DEPTH];

    // The tape wraps: only the low ADDR_W pointer bits select a cell.
    assign sel_idx = ptr_select[ADDR_W-1:0];
    assign wb_idx  = ptr_wb[ADDR_W-1:0];
    assign sel_oob = (ptr_select >> ADDR_W) != 16'd0;
    assign wb_oob  = (ptr_wb >> ADDR_W) != 16'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_next;
            if (state == S_CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == S_CLEAR && clr_idx == '1) begin
            state_next = S_RUN;
        end
    end

    // The ALU samples val_in on the edge that commits its write-back, so forward it.
    always_comb begin
        ready  = (state == S_RUN);
        val_in = '0;
        if (state == S_RUN) begin
            if (wb_en && wb_idx == sel_idx) begin
                val_in = wb_val;
            end else begin
                val_in = mem[sel_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (wb_en) begin
                mem[wb_idx] <= wb_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_data <= '0;
            oob      <= 1'b0;
        end else if (state == S_CLEAR) begin
            dbg_data <= '0;
        end else begin
            if (wb_en && wb_idx == dbg_addr) begin
                dbg_data <= wb_val;
            end else begin
                dbg_data <= mem[dbg_addr];
            end
            if (sel_oob || (wb_en && wb_oob)) begin
                oob <= 1'b1;
            end
        end
    end

endmodule

// File: doc/tape_mem.md
Name: tape_mem

Overview:
- Data tape for the threadbrain core: the responder on the ALU's cell interface.
- Each cycle it serves the cell addressed by ptr_select on val_in and accepts write-backs on ptr_wb/wb_val/wb_en.
- After reset it zeroes every cell with a clear sequencer, then raises ready.
- It also provides a registered debug read port for the print/trace logic.

Parameters:
- DATA_W, 16, cell width in bits.
- ADDR_W, 8, tape index width; DEPTH = 2^ADDR_W cells (default 256, so the ALU's start pointer 128 sits mid-tape).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- ptr_select  input  16  cell address to read this cycle (ALU next pointer).
- ptr_wb  input  16  cell address for write-back (ALU current pointer).
- wb_val  input  DATA_W  write-back data (ALU val_out).
- wb_en  input  1  write-back strobe.
- val_in  output  DATA_W  combinational cell value for ptr_select, fed to the ALU.
- ready  output  1  high once the tape is cleared; upstream holds the ALU while low.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  registered debug read data.
- oob  output  1  sticky flag: an in-use pointer had bits [15:ADDR_W] nonzero.

Behaviour:
- Storage: DEPTH x DATA_W register array with an asynchronous read port, a synchronous write port, and one registered debug read port.
- Addressing: the cell index is pointer[ADDR_W-1:0]; the tape wraps modulo DEPTH.
  - oob sets on any posedge in RUN where ptr_select[15:ADDR_W] != 0, or where wb_en=1 and ptr_wb[15:ADDR_W] != 0.
  - oob clears only on rst.
- States: CLEAR and RUN.
- Reset (posedge with rst=1):
  - state <= CLEAR, clr_idx <= 0.
  - ready <= 0, dbg_data <= 0, oob <= 0.
  - Memory contents are not touched by reset itself.
- CLEAR:
  - Each posedge writes mem[clr_idx] <= 0 and increments clr_idx.
  - On the posedge that writes index DEPTH-1: state <= RUN, ready <= 1.
  - With rst released before edge 1, ready is first high after exactly DEPTH posedges, i.e. 256 cycles by default.
  - wb_en is ignored.
  - val_in = 0.
  - dbg_data <= 0 each cycle.
- RUN write: if wb_en=1, mem[ptr_wb idx] <= wb_val at posedge.
- RUN read: val_in = mem[ptr_select idx], with combinational same-cycle forwarding.
  - If wb_en=1 and the two indices match, val_in = wb_val.
  - Required because the ALU samples val_in on the same edge that commits its write-back.
- Forwarding compares indices only, so wrapped aliases also forward.
- ready is registered and equals (state == RUN).
- Debug port: in RUN, dbg_data <= post-write value of mem[dbg_addr].
  - If wb_en=1 and the ptr_wb index equals dbg_addr, dbg_data <= wb_val.
  - Latency is 1 cycle.
- Arithmetic: no arithmetic on data; wb_val is stored verbatim, full DATA_W.
- rst asserted during CLEAR or RUN:
  - Next edge restarts CLEAR from index 0 and drops ready.
  - Any write-back presented on that edge is discarded.
  - The full tape is re-zeroed.
- rst held high: state stays in CLEAR with clr_idx=0; no memory writes occur.

Test Plan:
- Reset for 2 cycles, release, count edges -> ready low for exactly 256 posedges then high; dbg reads of 0, 128, 255 return 0x0000 after 1 cycle.
- RUN: ptr_select=ptr_wb=128, wb_en=1, wb_val=0x0001 -> val_in=0x0001 in the same cycle (forward); next cycle with wb_en=0, val_in=0x0001 (stored).
- Write 0x0005 at 128; next cycle ptr_wb=128, wb_en=1, wb_val=0x0004, ptr_select=129 -> val_in=0x0000; then ptr_select=128, wb_en=0 -> val_in=0x0004.
- Wrap/oob: wb_en=1, ptr_wb=0x0100, wb_val=0xBEEF -> cell 0 = 0xBEEF via dbg_addr=0, oob=1 next cycle and remains 1 thereafter; rst clears it.
- Debug same-cycle write: dbg_addr=7, wb_en=1, ptr_wb=7, wb_val=0x1234 -> dbg_data=0x1234 the following cycle.
- Mid-run reset: fill cells 10..12 with 0x00AA, assert rst for 1 cycle with wb_en=1 at cell 11 -> ready drops next cycle, after 256 cycles ready=1 and cells 10..12 read 0x0000.
